// File: rtl/rv_alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: op codes, the bit layout of the
// packed ALU command word, and the issue FSM state encoding.
package rv_alu_issue_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 32;
    localparam int CMD_W  = 14;

    // Operation codes presented on in_op_i.
    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd3;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd4;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd5;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd6;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd7;
    localparam logic [OP_W-1:0] OP_MULH = 4'd8;
    localparam logic [OP_W-1:0] OP_CMP  = 4'd9;
    localparam logic [OP_W-1:0] OP_CMPU = 4'd10;

    // Bit positions inside alu_cmd_o. OR/DIV/REM lines exist on the ALU but
    // are not driven by any op this stage issues.
    localparam int CMD_ADD         = 0;
    localparam int CMD_AND         = 1;
    localparam int CMD_OR          = 2;
    localparam int CMD_XOR         = 3;
    localparam int CMD_SHIFT       = 4;
    localparam int CMD_SHIFT_RIGHT = 5;
    localparam int CMD_MUL         = 6;
    localparam int CMD_MUL_HIGH    = 7;
    localparam int CMD_DIV         = 8;
    localparam int CMD_REM         = 9;
    localparam int CMD_CMP         = 10;
    localparam int CMD_NEGATE_OP2  = 11;
    localparam int CMD_SIGNED      = 12;
    localparam int CMD_SET_FLAGS   = 13;

    // Issue FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/rv_alu_issue_if.sv
// Bundle of the upstream, ALU-side and downstream signals of the issue stage.
// slave is the issue stage's view, master is the surrounding pipeline's view.
interface rv_alu_issue_if #(
    parameter int RD_W = 5
);
    import rv_alu_issue_pkg::*;

    // Upstream operation channel
    logic              in_valid_i;
    logic              in_ready_o;
    logic [OP_W-1:0]   in_op_i;
    logic [DATA_W-1:0] in_op1_i;
    logic [DATA_W-1:0] in_op2_i;
    logic [RD_W-1:0]   in_rd_i;

    // ALU side
    logic              alu_valid_o;
    logic [CMD_W-1:0]  alu_cmd_o;
    logic [DATA_W-1:0] alu_op1_o;
    logic [DATA_W-1:0] alu_op2_o;
    logic [DATA_W-1:0] alu_result_i;
    logic              alu_we_i;
    logic              alu_wait_i;

    // Downstream result channel
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [RD_W-1:0]   out_rd_o;

    logic              err_o;

    modport slave (
        input  in_valid_i, in_op_i, in_op1_i, in_op2_i, in_rd_i,
        input  alu_result_i, alu_we_i, alu_wait_i, out_ready_i,
        output in_ready_o, alu_valid_o, alu_cmd_o, alu_op1_o, alu_op2_o,
        output out_valid_o, out_data_o, out_rd_o, err_o
    );

    modport master (
        output in_valid_i, in_op_i, in_op1_i, in_op2_i, in_rd_i,
        output alu_result_i, alu_we_i, alu_wait_i, out_ready_i,
        input  in_ready_o, alu_valid_o, alu_cmd_o, alu_op1_o, alu_op2_o,
        input  out_valid_o, out_data_o, out_rd_o, err_o
    );

endinterface

// File: rtl/rv_alu_issue_dec.sv
// Combinational op-code to ALU command decode. Unknown op codes decode to an
// all-zero command.
module rv_alu_issue_dec
    import rv_alu_issue_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    output logic [CMD_W-1:0] cmd
);

    // Map each op onto the ALU command lines it needs.
    always_comb begin
        cmd = '0;
        case (op)
            OP_ADD: cmd[CMD_ADD] = 1'b1;
            OP_SUB: begin
                cmd[CMD_ADD]        = 1'b1;
                cmd[CMD_NEGATE_OP2] = 1'b1;
            end
            OP_AND: cmd[CMD_AND] = 1'b1;
            OP_XOR: cmd[CMD_XOR] = 1'b1;
            OP_SLL: cmd[CMD_SHIFT] = 1'b1;
            OP_SRL: begin
                cmd[CMD_SHIFT]       = 1'b1;
                cmd[CMD_SHIFT_RIGHT] = 1'b1;
            end
            OP_SRA: begin
                cmd[CMD_SHIFT]       = 1'b1;
                cmd[CMD_SHIFT_RIGHT] = 1'b1;
                cmd[CMD_SIGNED]      = 1'b1;
            end
            OP_MUL: cmd[CMD_MUL] = 1'b1;
            OP_MULH: begin
                cmd[CMD_MUL]      = 1'b1;
                cmd[CMD_MUL_HIGH] = 1'b1;
                cmd[CMD_SIGNED]   = 1'b1;
            end
            OP_CMP: begin
                cmd[CMD_CMP]        = 1'b1;
                cmd[CMD_NEGATE_OP2] = 1'b1;
                cmd[CMD_SIGNED]     = 1'b1;
                cmd[CMD_SET_FLAGS]  = 1'b1;
            end
            OP_CMPU: begin
                cmd[CMD_CMP]        = 1'b1;
                cmd[CMD_NEGATE_OP2] = 1'b1;
                cmd[CMD_SET_FLAGS]  = 1'b1;
            end
            default: cmd = '0;
        endcase
    end

endmodule

// File: rtl/rv_alu_issue.sv
// Single-slot issue stage between an operation queue and a (possibly
// multi-cycle) ALU. One operation in flight at a time; results land in a
// one-entry output register with valid/ready draining.
// Optional build macro RV_ALU_ISSUE_WDOG_EN adds a WAIT-state watchdog that
// abandons the operation after WDOG_MAX cycles and raises a sticky err_o.
module rv_alu_issue #(
    parameter int RD_W     = 5,
    parameter int WDOG_MAX = 64
) (
    input logic           clk_i,
    input logic           rst_i,
    rv_alu_issue_if.slave bus
);
    import rv_alu_issue_pkg::*;

    state_t             state_reg;
    state_t             state_next;

    logic [CMD_W-1:0]   dec_cmd;
    logic [CMD_W-1:0]   cmd_reg;
    logic [DATA_W-1:0]  op1_reg;
    logic [DATA_W-1:0]  op2_reg;
    logic [RD_W-1:0]    rd_reg;
    logic               is_cmp_reg;

    logic               out_valid_reg;
    logic [DATA_W-1:0]  out_data_reg;
    logic [RD_W-1:0]    out_rd_reg;

    logic               in_ready;
    logic               accept;
    logic               capture;
    logic               wdog_expired;

    rv_alu_issue_dec u_dec (
        .op  (bus.in_op_i),
        .cmd (dec_cmd)
    );

    // A new op may enter only when idle and the output slot is free or
    // being drained in this same cycle.
    assign in_ready = (state_reg == ST_IDLE) && (!out_valid_reg || bus.out_ready_i);
    assign accept   = bus.in_valid_i && in_ready;

    // Next-state logic; capture marks the cycle whose ALU result is kept.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (is_cmp_reg) begin
                    // Compares only update ALU flags; nothing to return.
                    state_next = ST_IDLE;
                end else if (bus.alu_we_i) begin
                    capture    = 1'b1;
                    state_next = ST_IDLE;
                end else if (bus.alu_wait_i) begin
                    state_next = ST_WAIT;
                end else begin
                    // ALU neither completed nor started: nothing to wait for.
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.alu_we_i) begin
                    capture    = 1'b1;
                    state_next = ST_IDLE;
                end else if (wdog_expired) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register and the operation latched at accept time.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= ST_IDLE;
            cmd_reg    <= '0;
            op1_reg    <= '0;
            op2_reg    <= '0;
            rd_reg     <= '0;
            is_cmp_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cmd_reg    <= dec_cmd;
                op1_reg    <= bus.in_op1_i;
                op2_reg    <= bus.in_op2_i;
                rd_reg     <= bus.in_rd_i;
                is_cmp_reg <= dec_cmd[CMD_CMP];
            end
        end
    end

    // Output slot: a fresh capture wins over a same-cycle drain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_rd_reg    <= '0;
        end else if (capture) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= bus.alu_result_i;
            out_rd_reg    <= rd_reg;
        end else if (out_valid_reg && bus.out_ready_i) begin
            out_valid_reg <= 1'b0;
        end
    end

`ifdef RV_ALU_ISSUE_WDOG_EN
    localparam int WDOG_CNT_W = $clog2(WDOG_MAX + 1);

    logic [WDOG_CNT_W-1:0] wdog_cnt_reg;
    logic                  err_reg;

    assign wdog_expired = (wdog_cnt_reg == WDOG_CNT_W'(WDOG_MAX - 1));

    // Count consecutive WAIT cycles without a result; expiry is sticky in err.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdog_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else if (state_reg == ST_WAIT && !bus.alu_we_i) begin
            if (wdog_expired) begin
                wdog_cnt_reg <= '0;
                err_reg      <= 1'b1;
            end else begin
                wdog_cnt_reg <= wdog_cnt_reg + WDOG_CNT_W'(1);
            end
        end else begin
            wdog_cnt_reg <= '0;
        end
    end

    assign bus.err_o = err_reg;
`else
    assign wdog_expired = 1'b0;
    assign bus.err_o    = 1'b0;
`endif

    assign bus.in_ready_o  = in_ready;
    assign bus.alu_valid_o = (state_reg == ST_ISSUE);
    assign bus.alu_cmd_o   = cmd_reg;
    assign bus.alu_op1_o   = op1_reg;
    assign bus.alu_op2_o   = op2_reg;
    assign bus.out_valid_o = out_valid_reg;
    assign bus.out_data_o  = out_data_reg;
    assign bus.out_rd_o    = out_rd_reg;

endmodule

// File: tb/tb_rv_alu_issue.sv
// Bench for rv_alu_issue: directed scenarios plus random traffic, checked
// against a transaction-level model of the issue slot and output slot.
module tb_rv_alu_issue;
    import rv_alu_issue_pkg::*;

    localparam int RD_W     = 5;
    localparam int WDOG_MAX = 64;

    logic clk = 1'b0;
    logic rst;

    int n_total = 0;
    int n_bad   = 0;
    int alu_valid_seen = 0;

    rv_alu_issue_if #(.RD_W(RD_W)) bus ();

    rv_alu_issue #(.RD_W(RD_W), .WDOG_MAX(WDOG_MAX)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: one in-flight op and one output slot.
    bit                m_busy, m_issue, m_cmp, m_full, m_err;
    logic [OP_W-1:0]   m_op;
    logic [31:0]       m_a, m_b, m_res, m_odata;
    logic [RD_W-1:0]   m_rd, m_ord;
    int                m_lat, m_wcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return 32'($signed(a) >>> b[4:0]);
            OP_MUL:  return a * b;
            OP_MULH: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return p[63:32];
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [CMD_W-1:0] exp_cmd(input logic [OP_W-1:0] op);
        logic [CMD_W-1:0] c;
        c = '0;
        case (op)
            OP_ADD:  c[CMD_ADD] = 1'b1;
            OP_SUB:  begin c[CMD_ADD] = 1'b1; c[CMD_NEGATE_OP2] = 1'b1; end
            OP_AND:  c[CMD_AND] = 1'b1;
            OP_XOR:  c[CMD_XOR] = 1'b1;
            OP_SLL:  c[CMD_SHIFT] = 1'b1;
            OP_SRL:  begin c[CMD_SHIFT] = 1'b1; c[CMD_SHIFT_RIGHT] = 1'b1; end
            OP_SRA:  begin c[CMD_SHIFT] = 1'b1; c[CMD_SHIFT_RIGHT] = 1'b1; c[CMD_SIGNED] = 1'b1; end
            OP_MUL:  c[CMD_MUL] = 1'b1;
            OP_MULH: begin c[CMD_MUL] = 1'b1; c[CMD_MUL_HIGH] = 1'b1; c[CMD_SIGNED] = 1'b1; end
            OP_CMP:  begin c[CMD_CMP] = 1'b1; c[CMD_NEGATE_OP2] = 1'b1; c[CMD_SIGNED] = 1'b1; c[CMD_SET_FLAGS] = 1'b1; end
            OP_CMPU: begin c[CMD_CMP] = 1'b1; c[CMD_NEGATE_OP2] = 1'b1; c[CMD_SET_FLAGS] = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_issue = 0; m_cmp = 0; m_full = 0; m_err = 0;
        m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_odata = '0;
        m_rd = '0; m_ord = '0; m_lat = 0; m_wcnt = 0;
    endtask

    // One clock cycle: act as the ALU, drive inputs, check outputs against
    // the model, then advance the model across the coming rising edge.
    // lat = number of WAIT cycles before the ALU returns (0 = same cycle).
    task automatic cycle(input bit iv, input logic [OP_W-1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [RD_W-1:0] rd, input bit ordy,
                         input int lat, input bit stray);
        bit          we, wt, rdy, acc, drn, cap;
        logic [31:0] res;
        @(negedge clk);
        we  = 0;
        wt  = 0;
        res = $urandom;
        if (m_busy && m_issue) begin
            if (!m_cmp) begin
                if (m_lat == 0) begin we = 1; res = m_res; end
                else wt = 1;
            end
        end else if (m_busy) begin
            if (m_wcnt == m_lat) begin we = 1; res = m_res; end
        end else begin
            we = stray;
        end
        bus.in_valid_i   = iv;
        bus.in_op_i      = op;
        bus.in_op1_i     = a;
        bus.in_op2_i     = b;
        bus.in_rd_i      = rd;
        bus.alu_we_i     = we;
        bus.alu_wait_i   = wt;
        bus.alu_result_i = res;
        bus.out_ready_i  = ordy;
        #1;
        rdy = !m_busy && (!m_full || ordy);
        chk("in_ready", 32'(bus.in_ready_o), 32'(rdy));
        chk("out_valid", 32'(bus.out_valid_o), 32'(m_full));
        if (m_full) begin
            chk("out_data", bus.out_data_o, m_odata);
            chk("out_rd", 32'(bus.out_rd_o), 32'(m_ord));
        end
        chk("alu_valid", 32'(bus.alu_valid_o), 32'(m_busy && m_issue));
        if (bus.alu_valid_o) alu_valid_seen++;
        if (m_busy) begin
            chk("alu_cmd", 32'(bus.alu_cmd_o), 32'(exp_cmd(m_op)));
            chk("alu_op1", bus.alu_op1_o, m_a);
            chk("alu_op2", bus.alu_op2_o, m_b);
        end
        chk("err", 32'(bus.err_o), 32'(m_err));

        acc = iv && rdy;
        drn = m_full && ordy;
        cap = 0;
        if (drn) $display("drain data=%h rd=%0d", m_odata, m_ord);
        if (m_busy) begin
            if (m_issue) begin
                if (m_cmp) m_busy = 0;
                else if (m_lat == 0) cap = 1;
                else begin m_issue = 0; m_wcnt = 1; end
            end else begin
                if (m_wcnt == m_lat) cap = 1;
`ifdef RV_ALU_ISSUE_WDOG_EN
                else if (m_wcnt == WDOG_MAX) begin m_busy = 0; m_err = 1; end
`endif
                else m_wcnt++;
            end
        end
        if (cap) begin
            m_busy = 0; m_full = 1; m_odata = m_res; m_ord = m_rd;
        end else if (drn) begin
            m_full = 0;
        end
        if (acc) begin
            m_busy = 1; m_issue = 1; m_op = op; m_a = a; m_b = b; m_rd = rd;
            m_lat = lat; m_res = alu_ref(op, a, b);
            m_cmp = (op == OP_CMP) || (op == OP_CMPU);
            $display("accept op=%0d a=%h b=%h rd=%0d lat=%0d", op, a, b, rd, lat);
        end
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, OP_ADD, 32'h0, 32'h0, '0, ordy, 0, 1'b0);
    endtask

    initial begin
        logic [CMD_W-1:0] cmd_s;
        rst = 1'b1;
        bus.in_valid_i = 0; bus.in_op_i = '0; bus.in_op1_i = '0; bus.in_op2_i = '0;
        bus.in_rd_i = '0; bus.alu_we_i = 0; bus.alu_wait_i = 0; bus.alu_result_i = '0;
        bus.out_ready_i = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid_o), 32'h0);
        chk("rst_alu_valid", 32'(bus.alu_valid_o), 32'h0);
        chk("rst_alu_cmd", 32'(bus.alu_cmd_o), 32'h0);
        chk("rst_out_data", bus.out_data_o, 32'h0);
        chk("rst_out_rd", 32'(bus.out_rd_o), 32'h0);
        chk("rst_err", 32'(bus.err_o), 32'h0);
        rst = 1'b0;
        idle(1'b0);
        chk("rst_in_ready", 32'(bus.in_ready_o), 32'h1);

        // Scenario 1: single-cycle ADD, result two cycles after accept.
        cycle(1'b1, OP_ADD, 32'h0000_0005, 32'hFFFF_FFFD, 5'd7, 1'b0, 0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("s1_valid", 32'(bus.out_valid_o), 32'h1);
        chk("s1_data", bus.out_data_o, 32'h0000_0002);
        chk("s1_rd", 32'(bus.out_rd_o), 32'd7);

        // Scenario 2: MUL with three WAIT cycles; accept drains the ADD result.
        alu_valid_seen = 0;
        cycle(1'b1, OP_MUL, 32'h0001_0000, 32'h0001_0000, 5'd12, 1'b1, 3, 1'b0);
        repeat (5) idle(1'b0);
        chk("s2_alu_valid_cycles", 32'(alu_valid_seen), 32'd1);
        chk("s2_data", bus.out_data_o, 32'h0000_0000);
        chk("s2_rd", 32'(bus.out_rd_o), 32'd12);

        // Scenario 3: held result blocks new ops, then accept+drain together.
        cycle(1'b1, OP_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 5'd3, 1'b0, 0, 1'b0);
        chk("s3_blocked", 32'(bus.in_ready_o), 32'h0);
        chk("s3_hold", bus.out_data_o, 32'h0000_0000);
        cycle(1'b1, OP_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 5'd3, 1'b1, 0, 1'b0);
        chk("s3_accept", 32'(bus.in_ready_o), 32'h1);
        idle(1'b0);
        chk("s3_drained", 32'(bus.out_valid_o), 32'h0);
        chk("s3_issue", 32'(bus.alu_valid_o), 32'h1);
        idle(1'b1);
        chk("s3_data", bus.out_data_o, 32'hA5A5_5A5A);
        idle(1'b1);

        // Scenario 4: signed compare produces no output entry.
        cycle(1'b1, OP_CMP, 32'h8000_0000, 32'h0000_0001, 5'd9, 1'b1, 0, 1'b0);
        idle(1'b1);
        cmd_s = bus.alu_cmd_o;
        chk("s4_cmp", 32'(cmd_s[CMD_CMP]), 32'h1);
        chk("s4_signed", 32'(cmd_s[CMD_SIGNED]), 32'h1);
        chk("s4_negate", 32'(cmd_s[CMD_NEGATE_OP2]), 32'h1);
        idle(1'b1);
        chk("s4_idle", 32'(bus.in_ready_o), 32'h1);
        chk("s4_no_out", 32'(bus.out_valid_o), 32'h0);

        // Scenario 5: reset in the second WAIT cycle; a late we is ignored.
        cycle(1'b1, OP_MULH, 32'h1234_5678, 32'h8765_4321, 5'd21, 1'b1, 10, 1'b0);
        idle(1'b1);
        idle(1'b1);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid_i = 0; bus.alu_we_i = 0; bus.alu_wait_i = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        bus.alu_we_i = 1'b1;
        bus.alu_result_i = 32'hDEAD_BEEF;
        #1;
        chk("s5_alu_valid", 32'(bus.alu_valid_o), 32'h0);
        chk("s5_alu_cmd", 32'(bus.alu_cmd_o), 32'h0);
        chk("s5_out_valid", 32'(bus.out_valid_o), 32'h0);
        chk("s5_out_data", bus.out_data_o, 32'h0);
        chk("s5_in_ready", 32'(bus.in_ready_o), 32'h1);
        cycle(1'b0, OP_ADD, 32'h0, 32'h0, '0, 1'b0, 0, 1'b1);
        chk("s5_late_we", 32'(bus.out_valid_o), 32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [OP_W-1:0] op;
            op = OP_W'($urandom_range(0, 10));
            cycle($urandom_range(0, 9) < 7, op, $urandom, $urandom, RD_W'($urandom),
                  $urandom_range(0, 9) < 6, int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
        end
        repeat (8) idle(1'b1);

`ifdef RV_ALU_ISSUE_WDOG_EN
        // Scenario 6: ALU never answers; watchdog abandons the op.
        cycle(1'b1, OP_MUL, 32'h3, 32'h5, 5'd1, 1'b1, 1000000, 1'b0);
        repeat (WDOG_MAX + 4) idle(1'b1);
        chk("s6_err", 32'(bus.err_o), 32'h1);
        chk("s6_in_ready", 32'(bus.in_ready_o), 32'h1);
        chk("s6_no_out", 32'(bus.out_valid_o), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
